// File: rtl/design1_wrapper.sv
// rtl/design1_wrapper.sv - AES-CTR AXI4-Lite register front end around an external AES-192 core
// Optional scan chain over functional registers when AES_SCAN_CHAIN_EN is defined.
module design1_wrapper #(
    parameter int ADDR_W = 8
) (
    input  logic              aclk_0,
    input  logic              aresetn_0,
    input  logic [ADDR_W-1:0] s_axi_awaddr,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [31:0]       s_axi_wdata,
    input  logic [3:0]        s_axi_wstrb,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    output logic [1:0]        s_axi_bresp,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,
    input  logic [ADDR_W-1:0] s_axi_araddr,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    output logic [31:0]       s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,
    output logic              core_start,
    output logic [191:0]      core_key,
    output logic [127:0]      core_block,
    input  logic              core_done,
    input  logic [127:0]      core_result
`ifdef AES_SCAN_CHAIN_EN
    ,
    input  logic              scan_en,
    input  logic              scan_in,
    output logic              scan_out
`endif
);

    localparam logic [5:0] W_START = 6'd0;
    localparam logic [5:0] W_PT    = 6'd1;
    localparam logic [5:0] W_KEY0  = 6'd5;
    localparam logic [5:0] W_DONE  = 6'd11;
    localparam logic [5:0] W_CT    = 6'd12;
    localparam logic [5:0] W_ST    = 6'd16;
    localparam logic [5:0] W_KEY1  = 6'd20;
    localparam logic [5:0] W_KEY2  = 6'd26;
    localparam logic [5:0] W_KSEL  = 6'd32;

    logic         start_bit;
    logic [127:0] pt;
    logic [191:0] key0;
    logic [191:0] key1;
    logic [191:0] key2;
    logic         done_bit;
    logic [127:0] ct;
    logic [127:0] st;
    logic [1:0]   key_sel;
    logic         busy;

    logic [191:0] sel_key;
    logic [31:0]  rd_word;
    logic         aw_top_ok;
    logic         ar_top_ok;
    logic         wr_fire;
    logic         rd_fire;
    logic         trigger;
    logic [5:0]   aw_idx;
    logic [5:0]   ar_idx;

    // Offsets above 0xFF are unmapped when the address bus is wider than the map.
    if (ADDR_W > 8) begin : g_wide
        assign aw_top_ok = (s_axi_awaddr[ADDR_W-1:8] == '0);
        assign ar_top_ok = (s_axi_araddr[ADDR_W-1:8] == '0);
    end else begin : g_narrow
        assign aw_top_ok = 1'b1;
        assign ar_top_ok = 1'b1;
    end

    assign aw_idx       = s_axi_awaddr[7:2];
    assign ar_idx       = s_axi_araddr[7:2];
    assign s_axi_wready = s_axi_awready;
    assign s_axi_bresp  = 2'b00;
    assign s_axi_rresp  = 2'b00;
    assign wr_fire      = s_axi_awready && s_axi_awvalid && s_axi_wvalid;
    assign rd_fire      = s_axi_arready && s_axi_arvalid;
    assign trigger      = wr_fire && aw_top_ok && (aw_idx == W_START) && s_axi_wdata[0]
                          && !start_bit && !busy;

    wire unused_ok = &{1'b0, s_axi_wstrb, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    always_comb begin
        case (key_sel)
            2'd1:    sel_key = key1;
            2'd2:    sel_key = key2;
            default: sel_key = key0;
        endcase
    end

    always_comb begin
        rd_word = '0;
        if (ar_top_ok) begin
            if (ar_idx == W_START) rd_word = {31'b0, start_bit};
            if (ar_idx == W_DONE)  rd_word = {31'b0, done_bit};
            if (ar_idx == W_KSEL)  rd_word = {30'b0, key_sel};
            for (int i = 0; i < 4; i++) begin
                if (ar_idx == W_PT + 6'(i)) rd_word = pt[32*i +: 32];
                if (ar_idx == W_CT + 6'(i)) rd_word = ct[32*i +: 32];
                if (ar_idx == W_ST + 6'(i)) rd_word = st[32*i +: 32];
            end
            for (int i = 0; i < 6; i++) begin
                if (ar_idx == W_KEY0 + 6'(i)) rd_word = key0[32*i +: 32];
                if (ar_idx == W_KEY1 + 6'(i)) rd_word = key1[32*i +: 32];
                if (ar_idx == W_KEY2 + 6'(i)) rd_word = key2[32*i +: 32];
            end
        end
    end

    always_ff @(posedge aclk_0 or negedge aresetn_0) begin
        if (!aresetn_0) begin
            s_axi_awready <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rdata   <= '0;
        end else begin
            s_axi_awready <= s_axi_awvalid && s_axi_wvalid && !s_axi_bvalid && !s_axi_awready;
            if (wr_fire)
                s_axi_bvalid <= 1'b1;
            else if (s_axi_bready)
                s_axi_bvalid <= 1'b0;
            s_axi_arready <= s_axi_arvalid && !s_axi_rvalid && !s_axi_arready;
            if (rd_fire) begin
                s_axi_rvalid <= 1'b1;
                s_axi_rdata  <= rd_word;
            end else if (s_axi_rready) begin
                s_axi_rvalid <= 1'b0;
            end
        end
    end

`ifdef AES_SCAN_CHAIN_EN
    logic [964:0] scan_vec;
    assign scan_vec = {key_sel, key2, key1, st, ct, done_bit, key0, pt, start_bit, busy};
    assign scan_out = scan_vec[0];
`endif

    always_ff @(posedge aclk_0 or negedge aresetn_0) begin
        if (!aresetn_0) begin
            start_bit  <= 1'b0;
            pt         <= '0;
            key0       <= '0;
            key1       <= '0;
            key2       <= '0;
            done_bit   <= 1'b0;
            ct         <= '0;
            st         <= '0;
            key_sel    <= '0;
            busy       <= 1'b0;
            core_start <= 1'b0;
            core_key   <= '0;
            core_block <= '0;
        end
`ifdef AES_SCAN_CHAIN_EN
        else if (scan_en) begin
            {key_sel, key2, key1, st, ct, done_bit, key0, pt, start_bit, busy}
                <= {scan_in, scan_vec[964:1]};
            core_start <= 1'b0;
        end
`endif
        else begin
            core_start <= 1'b0;
            if (wr_fire && aw_top_ok) begin
                if (aw_idx == W_START) start_bit <= s_axi_wdata[0];
                if (aw_idx == W_KSEL)  key_sel   <= s_axi_wdata[1:0];
                for (int i = 0; i < 4; i++) begin
                    if (aw_idx == W_PT + 6'(i)) pt[32*i +: 32] <= s_axi_wdata;
                    if (aw_idx == W_ST + 6'(i)) st[32*i +: 32] <= s_axi_wdata;
                end
                for (int i = 0; i < 6; i++) begin
                    if (aw_idx == W_KEY0 + 6'(i)) key0[32*i +: 32] <= s_axi_wdata;
                    if (aw_idx == W_KEY1 + 6'(i)) key1[32*i +: 32] <= s_axi_wdata;
                    if (aw_idx == W_KEY2 + 6'(i)) key2[32*i +: 32] <= s_axi_wdata;
                end
            end
            // Core inputs are snapshotted here so later register writes cannot disturb the block.
            if (trigger) begin
                busy       <= 1'b1;
                done_bit   <= 1'b0;
                core_start <= 1'b1;
                core_key   <= sel_key;
                core_block <= st;
            end
            if (core_done && busy) begin
                ct       <= core_result ^ pt;
                done_bit <= 1'b1;
                busy     <= 1'b0;
                st       <= st + 128'd1;
            end
        end
    end

endmodule

// File: tb/tb_design1_wrapper.sv
// tb/tb_design1_wrapper.sv - scoreboard bench for design1_wrapper with word-level reference model
module tb_design1_wrapper;

    logic         aclk_0 = 1'b0;
    logic         aresetn_0 = 1'b0;
    logic [7:0]   s_axi_awaddr = '0;
    logic         s_axi_awvalid = 1'b0;
    logic         s_axi_awready;
    logic [31:0]  s_axi_wdata = '0;
    logic [3:0]   s_axi_wstrb = 4'hf;
    logic         s_axi_wvalid = 1'b0;
    logic         s_axi_wready;
    logic [1:0]   s_axi_bresp;
    logic         s_axi_bvalid;
    logic         s_axi_bready = 1'b1;
    logic [7:0]   s_axi_araddr = '0;
    logic         s_axi_arvalid = 1'b0;
    logic         s_axi_arready;
    logic [31:0]  s_axi_rdata;
    logic [1:0]   s_axi_rresp;
    logic         s_axi_rvalid;
    logic         s_axi_rready = 1'b1;
    logic         core_start;
    logic [191:0] core_key;
    logic [127:0] core_block;
    logic         core_done = 1'b0;
    logic [127:0] core_result = '0;

    design1_wrapper #(.ADDR_W(8)) dut (
        .aclk_0(aclk_0), .aresetn_0(aresetn_0),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .core_start(core_start), .core_key(core_key), .core_block(core_block),
        .core_done(core_done), .core_result(core_result)
    );

    always #5 aclk_0 = ~aclk_0;

    int errors = 0;
    int checks = 0;

    // Reference model: register file as 64 words (offset/4), unmapped words stay zero.
    logic [31:0]  m_word [0:63];
    bit           m_busy;
    logic [191:0] exp_key_q [$];
    logic [127:0] exp_blk_q [$];
    logic [31:0]  exp_rd_q [$];
    int           exp_ad_q [$];

    int           n_start = 0;
    logic [191:0] last_key = '0;
    logic [127:0] last_blk = '0;
    int           stub_delay = 5;
    logic [127:0] stub_res = '0;

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bounded wait expired or unexpected event", name);
    endtask

    function automatic logic [127:0] m_vec(input int base);
        logic [127:0] v;
        for (int j = 0; j < 4; j++) v[32*j +: 32] = m_word[base+j];
        return v;
    endfunction

    function automatic void m_set_vec(input int base, input logic [127:0] v);
        for (int j = 0; j < 4; j++) m_word[base+j] = v[32*j +: 32];
    endfunction

    function automatic logic [191:0] m_key_of(input int base);
        logic [191:0] k;
        for (int j = 0; j < 6; j++) k[32*j +: 32] = m_word[base+j];
        return k;
    endfunction

    function automatic logic [191:0] m_key();
        case (m_word[32][1:0])
            2'd1:    return m_key_of(20);
            2'd2:    return m_key_of(26);
            default: return m_key_of(5);
        endcase
    endfunction

    function automatic void m_reset();
        for (int j = 0; j < 64; j++) m_word[j] = '0;
        m_busy = 1'b0;
    endfunction

    function automatic void m_write(input int w, input logic [31:0] d);
        if (w == 0) begin
            if (d[0] && !m_word[0][0] && !m_busy) begin
                m_busy = 1'b1;
                m_word[11] = '0;
                exp_key_q.push_back(m_key());
                exp_blk_q.push_back(m_vec(16));
            end
            m_word[0] = {31'b0, d[0]};
        end else if (w == 32) begin
            m_word[32] = {30'b0, d[1:0]};
        end else if ((w >= 1 && w <= 10) || (w >= 16 && w <= 31)) begin
            m_word[w] = d;
        end
    endfunction

    function automatic void m_done(input logic [127:0] r);
        if (!m_busy) return;
        m_set_vec(12, r ^ m_vec(1));
        m_word[11] = 32'd1;
        m_busy = 1'b0;
        m_set_vec(16, m_vec(16) + 128'd1);
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge aclk_0);
    endtask

    task automatic axi_write(input int w, input logic [31:0] d);
        int n;
        s_axi_awaddr  = 8'(w * 4);
        s_axi_wdata   = d;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        n = 0;
        do begin
            @(negedge aclk_0);
            n++;
        end while (!s_axi_awready && n < 20);
        if (!s_axi_awready) fail_now("aw_timeout");
        else m_write(w, d);
        @(negedge aclk_0);
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        check("bvalid", 192'(s_axi_bvalid), 192'd1);
        check("bresp", 192'(s_axi_bresp), 192'd0);
    endtask

    task automatic axi_read(input int w);
        int n;
        s_axi_araddr  = 8'(w * 4);
        s_axi_arvalid = 1'b1;
        exp_rd_q.push_back(m_word[w]);
        exp_ad_q.push_back(w);
        n = 0;
        do begin
            @(negedge aclk_0);
            n++;
        end while (!s_axi_arready && n < 20);
        if (!s_axi_arready) begin
            fail_now("ar_timeout");
            void'(exp_rd_q.pop_back());
            void'(exp_ad_q.pop_back());
        end
        @(negedge aclk_0);
        s_axi_arvalid = 1'b0;
    endtask

    // Monitor: read data and core requests are checked against the queues.
    initial begin
        logic [31:0] e;
        int a;
        forever begin
            @(negedge aclk_0);
            if (s_axi_rvalid) begin
                if (exp_rd_q.size() == 0) begin
                    fail_now("rvalid_unexpected");
                end else begin
                    e = exp_rd_q.pop_front();
                    a = exp_ad_q.pop_front();
                    check($sformatf("rdata@%02h", a * 4), 192'(s_axi_rdata), 192'(e));
                    check("rresp", 192'(s_axi_rresp), 192'd0);
                end
            end
            if (core_start) begin
                n_start++;
                last_key = core_key;
                last_blk = core_block;
                if (exp_key_q.size() == 0) begin
                    fail_now("core_start_unexpected");
                end else begin
                    check("core_key", core_key, exp_key_q.pop_front());
                    check("core_block", 192'(core_block), 192'(exp_blk_q.pop_front()));
                end
            end
        end
    end

    // Stub AES core: fixed latency, bench-chosen keystream.
    initial begin
        forever begin
            @(negedge aclk_0);
            if (core_start) begin
                repeat (stub_delay - 1) @(negedge aclk_0);
                core_result = stub_res;
                core_done   = 1'b1;
                m_done(stub_res);
                @(negedge aclk_0);
                core_done   = 1'b0;
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] kv [6];
        logic [31:0] ptv [4];
        logic [31:0] stv [4];
        int s0;
        kv  = '{32'h28aed2a6, 32'h2b7e1516, 32'h09cf4f3c, 32'habf71588, 32'h28aed2a6, 32'h2b7e1516};
        ptv = '{32'h66667777, 32'h44445555, 32'h22223333, 32'h00001111};
        stv = '{32'he0370734, 32'h313198a2, 32'h885a308d, 32'h3243f6a8};
        m_reset();

        repeat (3) @(negedge aclk_0);
        check("rst_awready", 192'(s_axi_awready), 192'd0);
        check("rst_bvalid", 192'(s_axi_bvalid), 192'd0);
        check("rst_arready", 192'(s_axi_arready), 192'd0);
        check("rst_rvalid", 192'(s_axi_rvalid), 192'd0);
        check("rst_core_start", 192'(core_start), 192'd0);
        aresetn_0 = 1'b1;
        @(negedge aclk_0);
        for (int w = 0; w <= 32; w++) axi_read(w);

        foreach (kv[j]) axi_write(5 + j, kv[j]);
        foreach (kv[j]) axi_write(20 + j, kv[j]);
        foreach (kv[j]) axi_write(26 + j, kv[j]);
        for (int w = 5; w <= 31; w++) axi_read(w);
        axi_write(11, 32'hffffffff);
        axi_write(12, 32'h12345678);
        axi_write(15, 32'hdeadbeef);
        axi_read(11); axi_read(12); axi_read(15);

        axi_write(32, 0);
        foreach (ptv[j]) axi_write(1 + j, ptv[j]);
        foreach (stv[j]) axi_write(16 + j, stv[j]);
        stub_res   = 128'h0123456789abcdef0123456789abcdef;
        stub_delay = 5;
        s0 = n_start;
        axi_write(0, 0); axi_write(0, 1); axi_write(0, 0);
        idle(12);
        check("vec_start_count", 192'(n_start - s0), 192'd1);
        check("vec_core_block", 192'(last_blk), 192'(128'h3243f6a8_885a308d_313198a2_e0370734));
        check("vec_core_key", last_key,
              192'h2b7e1516_28aed2a6_abf71588_09cf4f3c_2b7e1516_28aed2a6);
        for (int w = 11; w <= 19; w++) axi_read(w);

        for (int j = 0; j < 6; j++) axi_write(26 + j, $urandom);
        axi_write(32, 2);
        stub_delay = 40;
        stub_res   = {$urandom, $urandom, $urandom, $urandom};
        s0 = n_start;
        axi_write(0, 1);
        axi_write(0, 0); axi_write(0, 1); axi_write(0, 0); axi_write(0, 1);
        idle(45);
        check("busy_start_count", 192'(n_start - s0), 192'd1);
        check("sel2_core_key", last_key, m_key_of(26));
        for (int w = 0; w <= 19; w++) axi_read(w);

        for (int j = 0; j < 4; j++) axi_write(16 + j, 32'hffffffff);
        axi_write(0, 0);
        stub_delay = 3;
        axi_write(0, 1);
        idle(10);
        for (int w = 11; w <= 19; w++) axi_read(w);

        for (int it = 0; it < 8; it++) begin
            for (int j = 0; j < 4; j++) begin
                axi_write($urandom_range(1, 63), $urandom);
                axi_write(1 + j, $urandom);
                axi_write(16 + j, $urandom);
            end
            for (int j = 0; j < 6; j++) axi_write($urandom_range(5, 31), $urandom);
            axi_write(32, $urandom);
            stub_delay = $urandom_range(1, 8);
            stub_res   = {$urandom, $urandom, $urandom, $urandom};
            s0 = n_start;
            axi_write(0, 0);
            axi_write(0, 1);
            idle(stub_delay + 6);
            check("rand_start_count", 192'(n_start - s0), 192'd1);
            for (int w = 11; w <= 19; w++) axi_read(w);
            axi_read($urandom_range(0, 63));
        end

        axi_write(0, 0);
        stub_delay = 20;
        axi_write(0, 1);
        idle(3);
        aresetn_0 = 1'b0;
        m_reset();
        idle(2);
        aresetn_0 = 1'b1;
        idle(30);
        for (int w = 0; w <= 32; w++) axi_read(w);

        idle(5);
        if (exp_rd_q.size() != 0) fail_now("read_queue_not_drained");
        if (exp_key_q.size() != 0) fail_now("core_queue_not_drained");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
